// File: rtl/sram_arb.sv
// sram_arb: single-port async SRAM arbiter. Video fetch has priority; a
// starvation counter bounds CPU byte-access latency under continuous fetch.
module sram_arb #(
  parameter int unsigned CPU_MAXWAIT = 8
) (
  input  logic        mclk,
  input  logic        rst,
  input  logic [17:0] vaddr,
  input  logic        v_req,
  output logic        v_req_en,
  output logic [15:0] v_data,
  output logic        v_dv,
  input  logic        c_stb,
  input  logic [18:0] c_addr,
  input  logic        c_rnw,
  input  logic [7:0]  c_wdata,
  output logic [7:0]  c_rdata,
  output logic        c_ack,
  output logic        c_busy,
  output logic [17:0] sram_a,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MAXWAIT = CNT_W'(CPU_MAXWAIT);

  typedef enum logic [2:0] {S_IDLE, S_VRD, S_CRD, S_WS, S_WP, S_WH} state_t;

  state_t      state_q, state_d;
  logic        pend_q, pend_d;
  logic [18:0] p_addr_q, p_addr_d;
  logic        p_rnw_q, p_rnw_d;
  logic [7:0]  p_wdata_q, p_wdata_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic        c_busy_q, c_busy_d;
  logic        c_ack_q, c_ack_d;
  logic [7:0]  c_rdata_q, c_rdata_d;
  logic [15:0] v_data_q, v_data_d;
  logic        v_dv_q, v_dv_d;
  logic [17:0] sram_a_q, sram_a_d;
  logic [15:0] dq_o_q, dq_o_d;
  logic        dq_oe_q, dq_oe_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        ub_n_q, ub_n_d;
  logic        lb_n_q, lb_n_d;

  logic dec_ok, starve, cpu_grant, vid_grant, capture;

  // Arbitration, next bus cycle and the registered pin values for that cycle.
  always_comb begin
    dec_ok    = (state_q == S_IDLE) || (state_q == S_VRD) ||
                (state_q == S_CRD)  || (state_q == S_WH);
    starve    = pend_q && (cnt_q >= MAXWAIT);
    v_req_en  = dec_ok && !starve;
    vid_grant = v_req_en && v_req;
    cpu_grant = dec_ok && (starve || (!v_req && pend_q));
    capture   = c_stb && !c_busy_q;

    state_d = state_q;
    case (state_q)
      S_WS:    state_d = S_WP;
      S_WP:    state_d = S_WH;
      default: begin
        if (cpu_grant)      state_d = p_rnw_q ? S_CRD : S_WS;
        else if (vid_grant) state_d = S_VRD;
        else                state_d = S_IDLE;
      end
    endcase

    sram_a_d = sram_a_q;
    dq_o_d   = dq_o_q;
    dq_oe_d  = 1'b0;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    case (state_d)
      S_VRD: begin
        sram_a_d = vaddr;
        oe_n_d   = 1'b0;
        ub_n_d   = 1'b0;
        lb_n_d   = 1'b0;
      end
      S_CRD: begin
        sram_a_d = p_addr_q[18:1];
        oe_n_d   = 1'b0;
        ub_n_d   = !p_addr_q[0];
        lb_n_d   = p_addr_q[0];
      end
      S_WS, S_WP, S_WH: begin
        // Pending regs are frozen while busy, so address/data hold naturally.
        sram_a_d = p_addr_q[18:1];
        dq_o_d   = {p_wdata_q, p_wdata_q};
        dq_oe_d  = 1'b1;
        we_n_d   = (state_d != S_WP);
        ub_n_d   = !p_addr_q[0];
        lb_n_d   = p_addr_q[0];
      end
      default: ;
    endcase

    v_dv_d    = (state_q == S_VRD);
    v_data_d  = (state_q == S_VRD) ? sram_dq_i : v_data_q;
    c_ack_d   = (state_q == S_CRD) || (state_q == S_WP);
    c_rdata_d = c_rdata_q;
    if (state_q == S_CRD) c_rdata_d = p_addr_q[0] ? sram_dq_i[15:8] : sram_dq_i[7:0];

    c_busy_d = c_busy_q;
    if (capture) c_busy_d = 1'b1;
    if (c_ack_d) c_busy_d = 1'b0;

    pend_d    = pend_q;
    p_addr_d  = p_addr_q;
    p_rnw_d   = p_rnw_q;
    p_wdata_d = p_wdata_q;
    if (cpu_grant) pend_d = 1'b0;
    if (capture) begin
      pend_d    = 1'b1;
      p_addr_d  = c_addr;
      p_rnw_d   = c_rnw;
      p_wdata_d = c_wdata;
    end

    cnt_d = cnt_q;
    if (cpu_grant)                       cnt_d = '0;
    else if (pend_q && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and output registers; reset also aborts any access in flight.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pend_q    <= 1'b0;
      p_addr_q  <= '0;
      p_rnw_q   <= 1'b0;
      p_wdata_q <= '0;
      cnt_q     <= '0;
      c_busy_q  <= 1'b0;
      c_ack_q   <= 1'b0;
      c_rdata_q <= '0;
      v_data_q  <= '0;
      v_dv_q    <= 1'b0;
      sram_a_q  <= '0;
      dq_o_q    <= '0;
      dq_oe_q   <= 1'b0;
      oe_n_q    <= 1'b1;
      we_n_q    <= 1'b1;
      ub_n_q    <= 1'b1;
      lb_n_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      p_addr_q  <= p_addr_d;
      p_rnw_q   <= p_rnw_d;
      p_wdata_q <= p_wdata_d;
      cnt_q     <= cnt_d;
      c_busy_q  <= c_busy_d;
      c_ack_q   <= c_ack_d;
      c_rdata_q <= c_rdata_d;
      v_data_q  <= v_data_d;
      v_dv_q    <= v_dv_d;
      sram_a_q  <= sram_a_d;
      dq_o_q    <= dq_o_d;
      dq_oe_q   <= dq_oe_d;
      oe_n_q    <= oe_n_d;
      we_n_q    <= we_n_d;
      ub_n_q    <= ub_n_d;
      lb_n_q    <= lb_n_d;
    end
  end

  assign v_data     = v_data_q;
  assign v_dv       = v_dv_q;
  assign c_rdata    = c_rdata_q;
  assign c_ack      = c_ack_q;
  assign c_busy     = c_busy_q;
  assign sram_a     = sram_a_q;
  assign sram_dq_o  = dq_o_q;
  assign sram_dq_oe = dq_oe_q;
  assign sram_oe_n  = oe_n_q;
  assign sram_we_n  = we_n_q;
  assign sram_ub_n  = ub_n_q;
  assign sram_lb_n  = lb_n_q;

endmodule

// File: tb/tb_sram_arb.sv
// tb_sram_arb: directed tests for sram_arb with a small async SRAM model.
module tb_sram_arb;

  logic        mclk, rst;
  logic [17:0] vaddr;
  logic        v_req, v_req_en, v_dv;
  logic [15:0] v_data;
  logic        c_stb, c_rnw, c_ack, c_busy;
  logic [18:0] c_addr;
  logic [7:0]  c_wdata, c_rdata;
  logic [17:0] sram_a;
  logic [15:0] sram_dq_i, sram_dq_o;
  logic        sram_dq_oe, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [15:0] mem [0:1023];
  int          vcyc_q[$];
  logic [15:0] vdat_q[$];
  int          ack_cyc_q[$];
  logic [7:0]  ack_dat_q[$];
  int          wr_cnt = 0;
  logic [17:0] wr_a;
  logic [15:0] wr_d;
  logic [1:0]  wr_lanes;
  int          viol = 0;

  sram_arb #(.CPU_MAXWAIT(4)) dut (
    .mclk(mclk), .rst(rst), .vaddr(vaddr), .v_req(v_req), .v_req_en(v_req_en),
    .v_data(v_data), .v_dv(v_dv), .c_stb(c_stb), .c_addr(c_addr), .c_rnw(c_rnw),
    .c_wdata(c_wdata), .c_rdata(c_rdata), .c_ack(c_ack), .c_busy(c_busy),
    .sram_a(sram_a), .sram_dq_i(sram_dq_i), .sram_dq_o(sram_dq_o),
    .sram_dq_oe(sram_dq_oe), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
    .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  // Async SRAM read path: data appears while oe_n is low.
  assign sram_dq_i = sram_oe_n ? 16'h0000 : mem[sram_a[9:0]];

  always @(posedge mclk) cyc <= cyc + 1;

  // Mid-cycle monitors: video words, CPU acks, write pulses, bus rule breaks.
  always @(negedge mclk) begin
    if (v_dv) begin
      vcyc_q.push_back(cyc);
      vdat_q.push_back(v_data);
    end
    if (c_ack) begin
      ack_cyc_q.push_back(cyc);
      ack_dat_q.push_back(c_rdata);
    end
    if (!sram_we_n) begin
      wr_cnt   <= wr_cnt + 1;
      wr_a     <= sram_a;
      wr_d     <= sram_dq_o;
      wr_lanes <= {sram_ub_n, sram_lb_n};
    end
    if (!rst && ((!sram_oe_n && !sram_we_n) || (sram_dq_oe && !sram_oe_n) ||
                 (!sram_we_n && !sram_dq_oe)))
      viol <= viol + 1;
  end

  task automatic step;
    @(posedge mclk);
    #1;
  endtask

  task automatic test_reset;
    int ab, vb;
    rst = 1'b1;
    repeat (3) step;
    n_tests++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 4'b1111) begin n_fail++; $display("FAIL reset_strobes: got %b want 1111", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_tests++; if ({sram_a, sram_dq_o, sram_dq_oe} !== 35'h0) begin n_fail++; $display("FAIL reset_bus: a=%h dq_o=%h oe=%b want 0", sram_a, sram_dq_o, sram_dq_oe); end
    n_tests++; if ({v_data, v_dv, c_rdata, c_ack, c_busy} !== 27'h0) begin n_fail++; $display("FAIL reset_outs: vd=%h dv=%b rd=%h ack=%b busy=%b want 0", v_data, v_dv, c_rdata, c_ack, c_busy); end
    n_tests++; if (v_req_en !== 1'b1) begin n_fail++; $display("FAIL reset_v_req_en: got %b want 1", v_req_en); end
    #3 rst = 1'b0;
    step;
    // Start a video read and a CPU capture, then reset in the middle of VRD.
    v_req = 1'b1; vaddr = 18'h00010; c_stb = 1'b1; c_addr = 19'h00041; c_rnw = 1'b1;
    step;
    v_req = 1'b0; c_stb = 1'b0;
    n_tests++; if ({sram_oe_n, c_busy} !== 2'b01) begin n_fail++; $display("FAIL reset_pre_vrd: oe_n,busy got %b want 01", {sram_oe_n, c_busy}); end
    #2 rst = 1'b1;
    #1;
    n_tests++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 4'b1111) begin n_fail++; $display("FAIL reset_mid_strobes: got %b want 1111", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_tests++; if ({sram_dq_oe, v_dv, c_busy} !== 3'b000) begin n_fail++; $display("FAIL reset_mid_flags: dq_oe,dv,busy got %b want 000", {sram_dq_oe, v_dv, c_busy}); end
    n_tests++; if (sram_a !== 18'h0) begin n_fail++; $display("FAIL reset_mid_addr: got %h want 0", sram_a); end
    #2 rst = 1'b0;
    ab = ack_cyc_q.size(); vb = vdat_q.size();
    repeat (5) step;
    n_tests++; if (ack_cyc_q.size() != ab) begin n_fail++; $display("FAIL reset_no_cpu: acks got %0d want 0", ack_cyc_q.size() - ab); end
    n_tests++; if (vdat_q.size() != vb) begin n_fail++; $display("FAIL reset_no_video: words got %0d want 0", vdat_q.size() - vb); end
    n_tests++; if ({sram_oe_n, c_busy} !== 2'b10) begin n_fail++; $display("FAIL reset_idle: oe_n,busy got %b want 10", {sram_oe_n, c_busy}); end
  endtask

  task automatic test_video_burst;
    logic [15:0] exp_d [4];
    int vb, n0;
    exp_d = '{16'hA4A5, 16'hA4A4, 16'hA4A7, 16'hA4A6};
    vb = vdat_q.size(); n0 = cyc;
    for (int i = 0; i < 4; i++) begin
      vaddr = 18'h00100 + 18'(i); v_req = 1'b1;
      n_tests++; if (v_req_en !== 1'b1) begin n_fail++; $display("FAIL burst_en[%0d]: got %b want 1", i, v_req_en); end
      step;
    end
    v_req = 1'b0;
    repeat (4) step;
    n_tests++; if (vdat_q.size() - vb != 4) begin n_fail++; $display("FAIL burst_count: got %0d want 4", vdat_q.size() - vb); end
    for (int i = 0; i < 4; i++) begin
      if (vb + i < vdat_q.size()) begin
        n_tests++; if (vdat_q[vb+i] !== exp_d[i]) begin n_fail++; $display("FAIL burst_data[%0d]: got %h want %h", i, vdat_q[vb+i], exp_d[i]); end
        n_tests++; if (vcyc_q[vb+i] != n0 + 2 + i) begin n_fail++; $display("FAIL burst_cycle[%0d]: got %0d want %0d", i, vcyc_q[vb+i] - n0, 2 + i); end
      end
    end
  endtask

  task automatic test_cpu_read;
    mem[10'h100] = 16'h1234;
    c_stb = 1'b1; c_addr = 19'h00201; c_rnw = 1'b1;
    step;
    c_stb = 1'b0;
    n_tests++; if (c_busy !== 1'b1 || c_ack !== 1'b0) begin n_fail++; $display("FAIL rd_busy: busy,ack got %b%b want 10", c_busy, c_ack); end
    step;
    n_tests++; if (sram_a !== 18'h00100) begin n_fail++; $display("FAIL rd_addr: got %h want 00100", sram_a); end
    n_tests++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe} !== 5'b01010) begin n_fail++; $display("FAIL rd_strobes: oe,we,ub,lb,dqoe got %b want 01010", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n, sram_dq_oe}); end
    n_tests++; if (c_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_early: got %b want 0", c_ack); end
    step;
    n_tests++; if (c_ack !== 1'b1 || c_rdata !== 8'h12) begin n_fail++; $display("FAIL rd_ack: ack=%b rdata=%h want 1/12", c_ack, c_rdata); end
    n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL rd_busy_clr: got %b want 0", c_busy); end
    step;
    n_tests++; if (c_ack !== 1'b0) begin n_fail++; $display("FAIL rd_ack_pulse: got %b want 0", c_ack); end
  endtask

  task automatic test_cpu_write;
    int w0;
    w0 = wr_cnt;
    c_stb = 1'b1; c_addr = 19'h00010; c_rnw = 1'b0; c_wdata = 8'h5A;
    step;
    c_stb = 1'b0;
    n_tests++; if (c_busy !== 1'b1) begin n_fail++; $display("FAIL wr_busy: got %b want 1", c_busy); end
    step;
    n_tests++; if (sram_a !== 18'h00008 || sram_dq_o !== 16'h5A5A || sram_dq_oe !== 1'b1) begin n_fail++; $display("FAIL wr_ws_bus: a=%h dq=%h oe=%b want 00008/5a5a/1", sram_a, sram_dq_o, sram_dq_oe); end
    n_tests++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 4'b1110) begin n_fail++; $display("FAIL wr_ws_strobes: got %b want 1110", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_tests++; if (v_req_en !== 1'b0) begin n_fail++; $display("FAIL wr_ws_en: got %b want 0", v_req_en); end
    step;
    n_tests++; if ({sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 4'b1010) begin n_fail++; $display("FAIL wr_wp_strobes: got %b want 1010", {sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}); end
    n_tests++; if (v_req_en !== 1'b0) begin n_fail++; $display("FAIL wr_wp_en: got %b want 0", v_req_en); end
    step;
    n_tests++; if ({sram_oe_n, sram_we_n, sram_dq_oe, c_ack, c_busy} !== 5'b11110) begin n_fail++; $display("FAIL wr_wh: oe,we,dqoe,ack,busy got %b want 11110", {sram_oe_n, sram_we_n, sram_dq_oe, c_ack, c_busy}); end
    n_tests++; if (sram_a !== 18'h00008 || sram_dq_o !== 16'h5A5A) begin n_fail++; $display("FAIL wr_wh_hold: a=%h dq=%h want 00008/5a5a", sram_a, sram_dq_o); end
    step;
    n_tests++; if ({sram_dq_oe, c_ack, sram_we_n} !== 3'b001) begin n_fail++; $display("FAIL wr_after: dqoe,ack,we got %b want 001", {sram_dq_oe, c_ack, sram_we_n}); end
    n_tests++; if (wr_cnt - w0 != 1 || wr_a !== 18'h00008 || wr_d !== 16'h5A5A || wr_lanes !== 2'b10) begin n_fail++; $display("FAIL wr_pulse: n=%0d a=%h d=%h lanes=%b want 1/00008/5a5a/10", wr_cnt - w0, wr_a, wr_d, wr_lanes); end
  endtask

  task automatic test_starvation;
    logic en [0:15];
    int vb, ab, s_cyc;
    vb = vdat_q.size(); ab = ack_cyc_q.size(); s_cyc = 0;
    vaddr = 18'h00300; v_req = 1'b1; c_addr = 19'h00401; c_rnw = 1'b1;
    for (int k = 0; k < 16; k++) begin
      en[k] = v_req_en;
      c_stb = (k == 2);
      if (k == 2) s_cyc = cyc;
      step;
      if (en[k]) vaddr = vaddr + 18'd1;
    end
    c_stb = 1'b0; v_req = 1'b0;
    repeat (4) step;
    // Strobe at k=2; four denied decisions (k=3..6), CPU preempts at k=7.
    for (int k = 0; k < 16; k++) begin
      n_tests++; if (en[k] !== (k != 7)) begin n_fail++; $display("FAIL starve_en[%0d]: got %b want %b", k, en[k], (k != 7)); end
    end
    n_tests++; if (ack_cyc_q.size() - ab != 1) begin n_fail++; $display("FAIL starve_ack_count: got %0d want 1", ack_cyc_q.size() - ab); end
    if (ack_cyc_q.size() > ab) begin
      n_tests++; if (ack_cyc_q[ab] != s_cyc + 7 || ack_dat_q[ab] !== 8'hA7) begin n_fail++; $display("FAIL starve_ack: at +%0d data %h want +7/a7", ack_cyc_q[ab] - s_cyc, ack_dat_q[ab]); end
    end
    n_tests++; if (vdat_q.size() - vb != 15) begin n_fail++; $display("FAIL starve_vcount: got %0d want 15", vdat_q.size() - vb); end
    for (int i = 0; i < 15; i++) begin
      if (vb + i < vdat_q.size()) begin
        n_tests++; if (vdat_q[vb+i] !== ((16'h0300 + 16'(i)) ^ 16'hA5A5)) begin n_fail++; $display("FAIL starve_vdata[%0d]: got %h want %h", i, vdat_q[vb+i], (16'h0300 + 16'(i)) ^ 16'hA5A5); end
      end
    end
  endtask

  task automatic test_contended_write;
    logic en [0:17];
    int vb, ab, w0, s_cyc;
    vb = vdat_q.size(); ab = ack_cyc_q.size(); w0 = wr_cnt; s_cyc = 0;
    vaddr = 18'h00340; v_req = 1'b1; c_rnw = 1'b0;
    for (int k = 0; k < 18; k++) begin
      en[k]   = v_req_en;
      c_stb   = (k == 2) || (k == 4);
      c_addr  = (k == 4) ? 19'h00030 : 19'h00022;
      c_wdata = (k == 4) ? 8'h3C : 8'hC3;
      if (k == 2) s_cyc = cyc;
      step;
      if (en[k]) vaddr = vaddr + 18'd1;
    end
    c_stb = 1'b0; v_req = 1'b0;
    repeat (6) step;
    // Starvation decision at k=7, then WS (k=8) and WP (k=9) block video.
    for (int k = 0; k < 18; k++) begin
      n_tests++; if (en[k] !== !(k >= 7 && k <= 9)) begin n_fail++; $display("FAIL cwr_en[%0d]: got %b want %b", k, en[k], !(k >= 7 && k <= 9)); end
    end
    n_tests++; if (ack_cyc_q.size() - ab != 1) begin n_fail++; $display("FAIL cwr_ack_count: got %0d want 1", ack_cyc_q.size() - ab); end
    if (ack_cyc_q.size() > ab) begin
      n_tests++; if (ack_cyc_q[ab] != s_cyc + 8) begin n_fail++; $display("FAIL cwr_ack_cycle: got +%0d want +8", ack_cyc_q[ab] - s_cyc); end
    end
    n_tests++; if (wr_cnt - w0 != 1 || wr_a !== 18'h00011 || wr_d !== 16'hC3C3 || wr_lanes !== 2'b10) begin n_fail++; $display("FAIL cwr_pulse: n=%0d a=%h d=%h lanes=%b want 1/00011/c3c3/10", wr_cnt - w0, wr_a, wr_d, wr_lanes); end
    n_tests++; if (c_busy !== 1'b0) begin n_fail++; $display("FAIL cwr_busy: got %b want 0", c_busy); end
    n_tests++; if (vdat_q.size() - vb != 15) begin n_fail++; $display("FAIL cwr_vcount: got %0d want 15", vdat_q.size() - vb); end
    for (int i = 0; i < 15; i++) begin
      if (vb + i < vdat_q.size()) begin
        n_tests++; if (vdat_q[vb+i] !== ((16'h0340 + 16'(i)) ^ 16'hA5A5)) begin n_fail++; $display("FAIL cwr_vdata[%0d]: got %h want %h", i, vdat_q[vb+i], (16'h0340 + 16'(i)) ^ 16'hA5A5); end
      end
    end
  endtask

  task automatic test_bus_rules;
    n_tests++; if (viol != 0) begin n_fail++; $display("FAIL bus_rules: got %0d violating cycles want 0", viol); end
  endtask

  initial begin
    rst = 1'b1; vaddr = '0; v_req = 1'b0; c_stb = 1'b0; c_addr = '0; c_rnw = 1'b1; c_wdata = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i) ^ 16'hA5A5;
    test_reset;
    step;
    test_video_burst;
    step;
    test_cpu_read;
    step;
    test_cpu_write;
    repeat (2) step;
    test_starvation;
    repeat (2) step;
    test_contended_write;
    test_bus_rules;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
